// File: rtl/uart_pkg.sv
// Shared definitions for the UART word arbiter slice.
//   state_t : sequencer FSM state, 3-bit encoding
//   BYTE_W  : width of one transmitter byte
//   WORD_W  : width of a requester word in the default configuration
package uart_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        START   = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4,
        DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/uart_word_arbiter_rr_arbiter.sv
// Combinational round-robin pick, reusable by any N-way arbiter.
//   req          : request vector
//   last_grant   : index of the previous winner; search starts one above it
//   grant_onehot : one-hot winner (all zero when no request)
//   grant_idx    : binary index of the winner (0 when no request)
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant_onehot,
    output logic [IDX_W-1:0] grant_idx
);

    always_comb begin
        int  cand;
        logic found;
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        cand         = 0;
        // Walk N candidates starting just above the last winner, wrapping.
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last_grant) + k) % N;
            if (!found && req[cand]) begin
                found              = 1'b1;
                grant_onehot[cand] = 1'b1;
                grant_idx          = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_word_arbiter.sv
// Shares one byte-wide UART transmitter among NUM_REQ word producers.
// A round-robin winner is granted, its word captured, and the bytes sent
// LSB first through a tx_start / tx_busy handshake.
//   clk, rst_n      : clock, asynchronous active-low reset
//   req, data_in    : per-requester request level and packed words
//   grant           : one-hot pulse, word captured in this cycle
//   word_done       : pulse after the last byte left the line
//   done_id         : owner index, valid with word_done
//   busy            : high from grant through word_done
//   tx_start/tx_data: byte launch toward the transmitter
//   tx_busy         : transmitter busy
module uart_word_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    req,
    input  logic [NUM_REQ*BYTE_W*BYTES_PER_WORD-1:0] data_in,
    output logic [NUM_REQ-1:0]                    grant,
    output logic                                  word_done,
    output logic [$clog2(NUM_REQ)-1:0]            done_id,
    output logic                                  busy,
    output logic                                  tx_start,
    output logic [BYTE_W-1:0]                     tx_data,
    input  logic                                  tx_busy
);

    localparam int IDX_W     = $clog2(NUM_REQ);
    localparam int WORD_BITS = BYTE_W * BYTES_PER_WORD;
    localparam int CNT_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

    logic [WORD_BITS-1:0] word_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_word
            assign word_arr[gi] = data_in[gi*WORD_BITS +: WORD_BITS];
        end
    endgenerate

    state_t               state_reg, state_next;
    logic [WORD_BITS-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [IDX_W-1:0]     owner_reg, owner_next;
    logic [IDX_W-1:0]     last_grant_reg, last_grant_next;
    logic                 swb_reg, swb_next;   // start was issued while tx was busy

    logic [NUM_REQ-1:0]   grant_reg;
    logic                 word_done_reg;
    logic [IDX_W-1:0]     done_id_reg;
    logic                 busy_reg;
    logic                 tx_start_reg;
    logic [BYTE_W-1:0]    tx_data_reg;

    logic [NUM_REQ-1:0]   win_onehot;
    logic [IDX_W-1:0]     win_idx;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req          (req),
        .last_grant   (last_grant_reg),
        .grant_onehot (win_onehot),
        .grant_idx    (win_idx)
    );

    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        cnt_next        = cnt_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        swb_next        = swb_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next = GRANT;
                    owner_next = win_idx;
                end
            end
            GRANT: begin
                // data_in is only guaranteed valid during the grant cycle.
                shift_next = word_arr[owner_reg];
                cnt_next   = '0;
                state_next = START;
            end
            START: begin
                // A start seen while busy is dropped by the transmitter.
                swb_next   = tx_busy;
                state_next = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_next = WAIT_LO;
                end else if (swb_reg) begin
                    // Line went idle before we saw it busy again: retry now.
                    state_next = START;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (swb_reg) begin
                        state_next = START;          // resend the same byte
                    end else if (cnt_reg == LAST_BYTE) begin
                        state_next = DONE;
                    end else begin
                        shift_next = shift_reg >> BYTE_W;
                        cnt_next   = cnt_reg + 1'b1;
                        state_next = START;
                    end
                end
            end
            DONE: begin
                last_grant_next = owner_reg;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            cnt_reg        <= '0;
            owner_reg      <= '0;
            last_grant_reg <= IDX_W'(NUM_REQ - 1);
            swb_reg        <= 1'b0;
            grant_reg      <= '0;
            word_done_reg  <= 1'b0;
            done_id_reg    <= '0;
            busy_reg       <= 1'b0;
            tx_start_reg   <= 1'b0;
            tx_data_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            cnt_reg        <= cnt_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
            swb_reg        <= swb_next;
            grant_reg      <= (state_next == GRANT) ? win_onehot : '0;
            word_done_reg  <= (state_next == DONE);
            busy_reg       <= (state_next != IDLE);
            tx_start_reg   <= (state_next == START);
            if (state_next == DONE) begin
                done_id_reg <= owner_reg;
            end
            if (state_next == START) begin
                tx_data_reg <= shift_next[BYTE_W-1:0];
            end
        end
    end

    assign grant     = grant_reg;
    assign word_done = word_done_reg;
    assign done_id   = done_id_reg;
    assign busy      = busy_reg;
    assign tx_start  = tx_start_reg;
    assign tx_data   = tx_data_reg;

endmodule

// File: tb/tb_uart_word_arbiter.sv
module tb_uart_word_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [127:0] data_in;
    logic [3:0]   grant;
    logic         word_done;
    logic [1:0]   done_id;
    logic         busy;
    logic         tx_start;
    logic [7:0]   tx_data;
    logic         tx_busy;

    int checks = 0;
    int errors = 0;

    uart_word_arbiter #(.NUM_REQ(4), .BYTES_PER_WORD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .grant     (grant),
        .word_done (word_done),
        .done_id   (done_id),
        .busy      (busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;

    // Transmitter model: accepts a start only when idle, then busy 10 cycles.
    logic       model_busy = 1'b0;
    logic       force_busy = 1'b0;
    int         bcnt = 0;
    logic [7:0] line_q[$];
    assign tx_busy = model_busy | force_busy;

    always @(posedge clk) begin
        if (bcnt > 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) model_busy <= 1'b0;
        end else if (tx_start && !tx_busy) begin
            line_q.push_back(tx_data);
            bcnt       <= 10;
            model_busy <= 1'b1;
        end
    end

    // Observers.
    logic [3:0] grant_q[$];
    int         done_cnt = 0;
    int         overlap  = 0;
    always @(negedge clk) begin
        if (grant != 4'b0) grant_q.push_back(grant);
        if (word_done === 1'b1) done_cnt++;
        if ((int'(grant != 4'b0) + int'(tx_start) + int'(word_done)) > 1) overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input logic [1:0] exp_id);
        int n = 0;
        while (word_done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, {31'd0, word_done}, 32'd1);
        chk({tag, "_done_id"}, {30'd0, done_id}, {30'd0, exp_id});
        @(negedge clk);
    endtask

    task automatic chk_line(input string tag, input logic [31:0] word);
        chk({tag, "_nbytes"}, line_q.size(), 32'd4);
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("%s_byte%0d", tag, b),
                (line_q.size() > b) ? {24'd0, line_q[b]} : 32'hFFFF_FFFF,
                {24'd0, word[8*b +: 8]});
        end
    endtask

    logic [31:0] words [4];

    initial begin
        int snap;
        words[0] = 32'h11223344;
        words[1] = 32'hA1B2C3D4;
        words[2] = 32'hDEADBEEF;
        words[3] = 32'h55667788;
        rst_n = 1'b0;
        req   = 4'b0;
        for (int i = 0; i < 4; i++) data_in[i*32 +: 32] = words[i];

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_word_done", {31'd0, word_done}, 32'd0);
        chk("rst_done_id", {30'd0, done_id}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency: req sampled at edge t -> grant next cycle, tx_start one later
        req = 4'b0001;
        @(negedge clk);
        chk("lat_grant", {28'd0, grant}, 32'b0001);
        chk("lat_busy", {31'd0, busy}, 32'd1);
        chk("lat_txs_early", {31'd0, tx_start}, 32'd0);
        req = 4'b0;
        @(negedge clk);
        chk("lat_tx_start", {31'd0, tx_start}, 32'd1);
        chk("lat_tx_data", {24'd0, tx_data}, 32'h44);
        chk("lat_grant_off", {28'd0, grant}, 32'd0);
        wait_done("lat", 2'd0);
        chk_line("lat", words[0]);
        chk("lat_busy_end", {31'd0, busy}, 32'd0);
        $display("txn latency: word0 sent, done_id 0");

        // Single word from requester 2
        line_q.delete(); grant_q.delete();
        req = 4'b0100;
        @(negedge clk);
        chk("single_grant", {28'd0, grant}, 32'b0100);
        req = 4'b0;
        wait_done("single", 2'd2);
        chk_line("single", words[2]);
        chk("single_ngrant", grant_q.size(), 32'd1);
        chk("single_busy_end", {31'd0, busy}, 32'd0);
        $display("txn single: DEADBEEF sent, done_id 2");

        // Fairness after reset, all requesting continuously
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        line_q.delete(); grant_q.delete();
        req = 4'b1111;
        for (int w = 0; w < 6; w++) begin
            wait_done($sformatf("fair%0d", w), 2'(w % 4));
            if (w == 5) req = 4'b0;
        end
        chk("fair_ngrant", grant_q.size(), 32'd6);
        for (int w = 0; w < 6; w++) begin
            chk($sformatf("fair_grant%0d", w),
                (grant_q.size() > w) ? {28'd0, grant_q[w]} : 32'hFFFF_FFFF,
                32'd1 << (w % 4));
        end
        chk("fair_nbytes", line_q.size(), 32'd24);
        for (int k = 0; k < 24; k++) begin
            chk($sformatf("fair_byte%0d", k),
                (line_q.size() > k) ? {24'd0, line_q[k]} : 32'hFFFF_FFFF,
                {24'd0, words[(k / 4) % 4][8*(k % 4) +: 8]});
        end
        $display("txn fairness: 6 words, order 0 1 2 3 0 1");

        // Early drop of req[1] the cycle after its grant
        line_q.delete();
        req = 4'b0010;
        @(negedge clk);
        chk("drop_grant", {28'd0, grant}, 32'b0010);
        @(negedge clk);
        req = 4'b0;
        wait_done("drop", 2'd1);
        chk_line("drop", words[1]);
        $display("txn early_drop: word1 sent in full");

        // Reset during the second byte's WAIT_LO
        line_q.delete();
        req = 4'b1000;
        @(negedge clk);
        chk("mid_grant", {28'd0, grant}, 32'b1000);
        req = 4'b0;
        snap = 0;
        while (line_q.size() < 2 && snap < 200) begin
            @(negedge clk);
            snap++;
        end
        chk("mid_second_byte", {31'd0, line_q.size() >= 2}, 32'd1);
        repeat (3) @(negedge clk);
        snap = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("mid_rst_grant", {28'd0, grant}, 32'd0);
        chk("mid_rst_done_id", {30'd0, done_id}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        line_q.delete();
        repeat (2) @(negedge clk);
        chk("mid_no_done", done_cnt, snap);
        chk("mid_idle", {31'd0, busy}, 32'd0);
        req = 4'b1001;
        @(negedge clk);
        chk("mid_next_grant", {28'd0, grant}, 32'b0001);
        req = 4'b0;
        wait_done("mid_next", 2'd0);
        chk_line("mid_next", words[0]);
        $display("txn reset_mid_word: abandoned, next grant to 0");

        // tx_busy high when entering START
        repeat (15) @(negedge clk);
        line_q.delete();
        force_busy = 1'b1;
        req = 4'b0100;
        @(negedge clk);
        chk("bsy_grant", {28'd0, grant}, 32'b0100);
        req = 4'b0;
        @(negedge clk);
        chk("bsy_tx_start", {31'd0, tx_start}, 32'd1);
        repeat (6) @(negedge clk);
        chk("bsy_nothing_sent", line_q.size(), 32'd0);
        force_busy = 1'b0;
        wait_done("bsy", 2'd2);
        chk_line("bsy", words[2]);
        $display("txn busy_at_start: byte restarted, word2 intact");

        chk("no_overlap", overlap, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
